inst_rom: RTL and testbench
===========================

# inst_rom

Instruction-memory responder for the five-stage MIPS core: the other end of the core's fetch interface (`rom_ce`/`rom_addr` in, `rom_data` out). It serves instruction words from an on-chip word array with zero-latency reads and contains a byte-stream program loader FSM. The loader fills the array and holds the core in reset while loading. It sits beside the `cpu` top at the SoC level.

## Interface
- `ADDR_W`, 10: word-address width; depth = 2^ADDR_W words.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rom_ce_i`  in  1  fetch enable from the core's PC.
- `rom_addr_i`  in  32  fetch byte address.
- `rom_data_o`  out  32  instruction word.
- `addr_err_o`  out  1  registered flag: last enabled fetch was misaligned or out of range.
- `ld_start_i`  in  1  start a program load at word 0.
- `ld_len_i`  in  ADDR_W+1  number of words to load.
- `ld_valid_i`  in  1  loader byte valid.
- `ld_byte_i`  in  8  loader byte.
- `ld_ready_o`  out  1  loader ready to accept a byte.
- `ld_busy_o`  out  1  load in progress.
- `ld_done_o`  out  1  one-cycle pulse at load completion.
- `cpu_hold_o`  out  1  drive into the core's reset while asserted.
- `chk_o`  out  32  XOR checksum of loaded words (`INST_ROM_CHK_EN` only).

## Operation
- Read path is combinational: `rom_data_o = mem[rom_addr_i[ADDR_W+1:2]]`.
- `rom_data_o` is 32'h0 (NOP) when any of the following holds:
  - `rom_ce_i`=0;
  - `ld_busy_o`=1;
  - `rom_addr_i[1:0]`≠0;
  - `rom_addr_i[31:ADDR_W+2]`≠0.
- `addr_err_o` is registered every cycle with `rom_ce_i & (misaligned | out_of_range)`.
- Loader FSM states and transitions:
  - IDLE: on `ld_start_i`, capture `min(ld_len_i, 2^ADDR_W)` as `len`; clear the word counter, byte counter and checksum. If `len`=0, go to DONE; otherwise go to LOAD.
  - LOAD: `ld_ready_o`=1. Each accepted byte (`ld_valid_i & ld_ready_o`) shifts into the assembly register big-endian; the first byte lands in [31:24]. On the 4th byte, the assembled word is written to `mem[wcnt]` at that edge, `wcnt` increments, and the byte counter wraps to 0. If `wcnt`=`len`-1 at that write, go to DONE.
  - DONE: `ld_done_o`=1 for exactly one cycle, then go to IDLE.
- `ld_start_i` is ignored outside IDLE.
- `ld_valid_i` is ignored outside LOAD.
- `ld_busy_o` = `cpu_hold_o` = (state≠IDLE).
- Memory contents are not cleared by reset or by a new load. Words beyond `len` retain their old values.

## Timing
- Reset values: state IDLE; counters 0; `ld_ready_o`, `ld_busy_o`, `ld_done_o`, `cpu_hold_o`, `addr_err_o` all 0; `chk_o` 0.
- Fetch latency is 0 cycles: the address applied during cycle N gives data in cycle N, which the core's if_id register samples at the end of N.
- `cpu_hold_o` and `ld_busy_o` rise in the cycle after `ld_start_i` is sampled.
- `ld_done_o` pulses in the cycle after the last byte is accepted. Hold and busy fall one cycle later.
- `ld_start_i` with `len`=0: hold is asserted for exactly one cycle (DONE), together with the done pulse.
- Byte stalls (`ld_valid_i`=0) leave all counters unchanged; there is no timeout.
- Reset mid-load: the FSM returns to IDLE immediately, the partial word is discarded, and words already written remain in memory.
- A fetch of the word being written in the same cycle is not possible: reads return NOP while busy.

## Configuration
- `INST_ROM_CHK_EN` defined:
  - `chk_o` is present.
  - It is cleared on an accepted `ld_start_i`.
  - It XOR-accumulates each word at its write edge.
  - It holds its value after DONE until the next start.
- `INST_ROM_CHK_EN` undefined: the `chk_o` port and the accumulator are absent.

## Structure
- Shared package/define file holds:
  - default `ADDR_W`;
  - FSM state encodings (IDLE/LOAD/DONE);
  - `NOP_INST` = 32'h0.
- Sub-module `inst_rom_ram`: 2^ADDR_W×32 array with one synchronous write port and one asynchronous read port. The FSM, counters, checksum and read gating stay in `inst_rom`.

## Test plan
- Load `len`=2 with bytes 34 01 00 05, 3C 02 12 34 → `mem[0]`=32'h34010005, `mem[1]`=32'h3C021234; `ld_done_o` pulses 1 cycle after the 8th byte; with the macro, `chk_o`=32'h08031231.
- Idle fetches: `rom_ce_i`=1 with addr 0x0 then 0x4 → `rom_data_o` equals the loaded words in the same cycle. `rom_ce_i`=0 → 0.
- Bad addresses: addr 0x2 → data 0 and `addr_err_o`=1 next cycle. Addr (2^ADDR_W)*4 → data 0 and `addr_err_o`=1.
- Valid gaps: insert 3 idle cycles between each byte of a 1-word load → correct word written; `cpu_hold_o` stays high throughout and drops 2 cycles after the last byte.
- Reset mid-load: assert `rst`=0 after 6 of 8 bytes → `mem[0]` written, `mem[1]` unchanged, all outputs at reset values.
- Length handling: `ld_len_i`=0 → `ld_done_o` in the cycle after start, no writes. `ld_len_i`=2^ADDR_W+1 → clamped; done after exactly 4×2^ADDR_W bytes.

Source files
------------

// File: rtl/inst_rom_pkg.sv
// inst_rom_pkg: shared constants and types for the instruction ROM and its loader.
package inst_rom_pkg;

  // Default word-address width; the array depth is 2^INST_ROM_ADDR_W words.
  localparam int INST_ROM_ADDR_W = 10;

  // Instruction returned whenever a fetch is not served (all-zero word is a MIPS NOP).
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // Loader FSM state encodings.
  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } ld_state_t;

  // Big-endian byte assembly: earlier bytes move toward the MSB.
  function automatic logic [31:0] shift_in_byte(input logic [31:0] acc, input logic [7:0] b);
    return {acc[23:0], b};
  endfunction

endpackage

// File: rtl/inst_rom_ram.sv
// inst_rom_ram: 2^ADDR_W x 32 word array, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module inst_rom_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  // Write port: one word per clock when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Zero-latency read port.
  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom.sv
// inst_rom: instruction-memory responder for the five-stage MIPS core.
// Serves zero-latency fetches from an on-chip word array and contains a
// byte-stream program loader that fills the array while holding the core in reset.
// Optional feature macro: INST_ROM_CHK_EN adds chk_o, an XOR checksum of the
// words written by the most recent load.
//
// Loader states:
//   state   | meaning
//   LD_IDLE | waiting for ld_start_i; fetches are served
//   LD_LOAD | accepting bytes, writing one word per four bytes
//   LD_DONE | single-cycle completion pulse, core still held
module inst_rom
  import inst_rom_pkg::*;
#(
  parameter int ADDR_W = INST_ROM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [31:0]       rom_data_o,
  output logic              addr_err_o,
  input  logic              ld_start_i,
  input  logic [ADDR_W:0]   ld_len_i,
  input  logic              ld_valid_i,
  input  logic [7:0]        ld_byte_i,
  output logic              ld_ready_o,
  output logic              ld_busy_o,
  output logic              ld_done_o,
  output logic              cpu_hold_o
`ifdef INST_ROM_CHK_EN
  ,
  output logic [31:0]       chk_o
`endif
);

  // Full depth expressed in the length-port width (2^ADDR_W).
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  ld_state_t         state;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] wcnt;
  logic [1:0]        bcnt;
  logic [31:0]       asm_word;

  logic [ADDR_W:0]   len_clamped;
  logic              byte_acc;
  logic              word_wr;
  logic              last_word;
  logic [31:0]       word_full;

  logic              misaligned;
  logic              out_of_range;
  logic              fetch_ok;
  logic [31:0]       ram_rdata;

  // Requests longer than the array are clamped to its depth.
  assign len_clamped = (ld_len_i > DEPTH) ? DEPTH : ld_len_i;

  // ld_ready_o is high exactly while in LD_LOAD, so it doubles as the state qualifier.
  assign byte_acc  = ld_ready_o & ld_valid_i;
  assign word_full = shift_in_byte(asm_word, ld_byte_i);
  assign word_wr   = byte_acc & (bcnt == 2'd3);
  assign last_word = ({1'b0, wcnt} == (len - (ADDR_W+1)'(1)));

  // Loader FSM with its counters and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= LD_IDLE;
      len        <= '0;
      wcnt       <= '0;
      bcnt       <= '0;
      asm_word   <= '0;
      ld_ready_o <= 1'b0;
      ld_busy_o  <= 1'b0;
      ld_done_o  <= 1'b0;
    end else begin
      case (state)
        LD_IDLE: begin
          if (ld_start_i) begin
            len       <= len_clamped;
            wcnt      <= '0;
            bcnt      <= '0;
            asm_word  <= '0;
            ld_busy_o <= 1'b1;
            if (len_clamped == '0) begin
              state     <= LD_DONE;
              ld_done_o <= 1'b1;
            end else begin
              state      <= LD_LOAD;
              ld_ready_o <= 1'b1;
            end
          end
        end

        LD_LOAD: begin
          if (byte_acc) begin
            asm_word <= word_full;
            bcnt     <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              wcnt <= wcnt + ADDR_W'(1);
              if (last_word) begin
                state      <= LD_DONE;
                ld_ready_o <= 1'b0;
                ld_done_o  <= 1'b1;
              end
            end
          end
        end

        LD_DONE: begin
          state     <= LD_IDLE;
          ld_done_o <= 1'b0;
          ld_busy_o <= 1'b0;
        end

        default: begin
          state      <= LD_IDLE;
          ld_ready_o <= 1'b0;
          ld_busy_o  <= 1'b0;
          ld_done_o  <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_hold_o = ld_busy_o;

`ifdef INST_ROM_CHK_EN
  logic [31:0] chk;

  // Checksum restarts with each accepted load and folds in every written word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk <= '0;
    end else if ((state == LD_IDLE) && ld_start_i) begin
      chk <= '0;
    end else if (word_wr) begin
      chk <= chk ^ word_full;
    end
  end

  assign chk_o = chk;
`endif

  inst_rom_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (word_wr),
    .waddr (wcnt),
    .wdata (word_full),
    .raddr (rom_addr_i[ADDR_W+1:2]),
    .rdata (ram_rdata)
  );

  assign misaligned   = |rom_addr_i[1:0];
  assign out_of_range = |rom_addr_i[31:ADDR_W+2];

  // A fetch is served only when idle; during a load the core sees NOPs, which
  // also rules out reading a word in the same cycle it is written.
  assign fetch_ok   = rom_ce_i & ~ld_busy_o & ~misaligned & ~out_of_range;
  assign rom_data_o = fetch_ok ? ram_rdata : NOP_INST;

  // Bad-address flag for the most recent enabled fetch, updated every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_err_o <= 1'b0;
    end else begin
      addr_err_o <= rom_ce_i & (misaligned | out_of_range);
    end
  end

endmodule

// File: tb/tb_inst_rom.sv
// tb_inst_rom: randomized bench for inst_rom with a word/byte-count level model.
module tb_inst_rom;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rom_ce_i = 1'b0;
  logic [31:0]   rom_addr_i = '0;
  logic [31:0]   rom_data_o;
  logic          addr_err_o;
  logic          ld_start_i = 1'b0;
  logic [AW:0]   ld_len_i = '0;
  logic          ld_valid_i = 1'b0;
  logic [7:0]    ld_byte_i = '0;
  logic          ld_ready_o;
  logic          ld_busy_o;
  logic          ld_done_o;
  logic          cpu_hold_o;
`ifdef INST_ROM_CHK_EN
  logic [31:0]   chk_o;
`endif

  always #5 clk = ~clk;

  inst_rom #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_i   (rom_ce_i),
    .rom_addr_i (rom_addr_i),
    .rom_data_o (rom_data_o),
    .addr_err_o (addr_err_o),
    .ld_start_i (ld_start_i),
    .ld_len_i   (ld_len_i),
    .ld_valid_i (ld_valid_i),
    .ld_byte_i  (ld_byte_i),
    .ld_ready_o (ld_ready_o),
    .ld_busy_o  (ld_busy_o),
    .ld_done_o  (ld_done_o),
    .cpu_hold_o (cpu_hold_o)
`ifdef INST_ROM_CHK_EN
    ,
    .chk_o      (chk_o)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference model: a load is "active" from the cycle after start until the
  // cycle after the final word; every 4th accepted byte completes one word.
  logic [31:0] mem_model [DEPTH];
  bit          known [DEPTH];
  bit          m_active = 0;
  bit          m_done   = 0;
  bit          m_err    = 0;
  int          m_len    = 0;
  int          m_nbytes = 0;
  int          m_widx   = 0;
  logic [31:0] m_word   = '0;
  logic [31:0] m_chk    = '0;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_active = 0; m_done = 0; m_err = 0; m_nbytes = 0; m_widx = 0; m_word = '0; m_chk = '0;
    end else begin
      m_err = rom_ce_i && ((rom_addr_i[1:0] != 2'b00) || ((rom_addr_i >> (AW + 2)) != 0));
      if (m_done) begin
        m_done = 0;
        m_active = 0;
      end else if (m_active) begin
        if (ld_valid_i) begin
          m_word = {m_word[23:0], ld_byte_i};
          m_nbytes++;
          if (m_nbytes % 4 == 0) begin
            mem_model[m_widx] = m_word;
            known[m_widx] = 1;
            m_chk ^= m_word;
            m_widx++;
            if (m_widx == m_len) m_done = 1;
          end
        end
      end else if (ld_start_i) begin
        m_len = (int'(ld_len_i) > DEPTH) ? DEPTH : int'(ld_len_i);
        m_nbytes = 0; m_widx = 0; m_chk = '0;
        m_active = 1;
        if (m_len == 0) m_done = 1;
      end
    end
  end

  // Compare process: every cycle, on the falling edge.
  initial forever begin
    int idx;
    @(negedge clk);
    check("busy",     32'(ld_busy_o),  32'(m_active));
    check("hold",     32'(cpu_hold_o), 32'(m_active));
    check("ready",    32'(ld_ready_o), 32'(m_active && !m_done));
    check("done",     32'(ld_done_o),  32'(m_done));
    check("addr_err", 32'(addr_err_o), 32'(m_err));
`ifdef INST_ROM_CHK_EN
    check("chk", chk_o, m_chk);
`endif
    idx = int'(rom_addr_i[AW+1:2]);
    if (rom_ce_i && !m_active && rom_addr_i[1:0] == 2'b00 && ((rom_addr_i >> (AW + 2)) == 0)) begin
      if (known[idx]) check("fetch", rom_data_o, mem_model[idx]);
    end else begin
      check("fetch_nop", rom_data_o, 32'h0);
    end
  end

  bit noise = 0;

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 9);
    case (r)
      0, 1, 2, 3, 4, 5: return 32'($urandom_range(0, 3)) << 2;
      6:       return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      7:       return 32'(DEPTH * 4) + (32'($urandom_range(0, 63)) << 2);
      8:       return $urandom | 32'h8000_0000;
      default: return 32'($urandom_range(0, DEPTH - 1)) << 2;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (noise) begin
      rom_ce_i   = 1'($urandom_range(0, 1));
      rom_addr_i = rand_addr();
    end
  endtask

  task automatic do_start(input int len);
    ld_len_i   = (AW+1)'(len);
    ld_start_i = 1'b1;
    tick();
    ld_start_i = 1'b0;
    ld_len_i   = (AW+1)'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit snoise);
    ld_valid_i = 1'b1;
    ld_byte_i  = b;
    if (snoise) ld_start_i = 1'($urandom_range(0, 1));
    tick();
    ld_valid_i = 1'b0;
    ld_start_i = 1'b0;
    ld_byte_i  = 8'($urandom);
    repeat (gap) tick();
  endtask

  task automatic fetch_now(input string name, input logic [31:0] addr, input logic [31:0] exp);
    rom_ce_i   = 1'b1;
    rom_addr_i = addr;
    #1;
    check(name, rom_data_o, exp);
  endtask

  logic [7:0] prog0 [8] = '{8'h34, 8'h01, 8'h00, 8'h05, 8'h3C, 8'h02, 8'h12, 8'h34};
  logic [7:0] prog1 [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
  logic [7:0] prog2 [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  initial begin
    int cnt;
    int len;

    repeat (3) tick();
    check("rst_busy", 32'(ld_busy_o), 32'h0);
    check("rst_done", 32'(ld_done_o), 32'h0);
    rst = 1'b1;
    tick();

    // Two-word program, back-to-back bytes.
    do_start(2);
    for (int i = 0; i < 8; i++) send_byte(prog0[i], 0, 1'b0);
    check("done_after_8th", 32'(ld_done_o), 32'h1);
    check("hold_in_done", 32'(cpu_hold_o), 32'h1);
`ifdef INST_ROM_CHK_EN
    check("chk_literal", chk_o, 32'h08031231);
`endif
    tick();
    check("hold_released", 32'(cpu_hold_o), 32'h0);
    fetch_now("fetch_w0", 32'h0, 32'h34010005);
    fetch_now("fetch_w1", 32'h4, 32'h3C021234);
    rom_ce_i = 1'b0;
    #1 check("ce_off", rom_data_o, 32'h0);

    // Bad addresses.
    fetch_now("misaligned_nop", 32'h2, 32'h0);
    tick();
    check("misaligned_err", 32'(addr_err_o), 32'h1);
    fetch_now("oor_nop", 32'(DEPTH * 4), 32'h0);
    tick();
    check("oor_err", 32'(addr_err_o), 32'h1);
    rom_ce_i = 1'b0;
    tick();
    check("err_clear", 32'(addr_err_o), 32'h0);

    // Zero-length load.
    do_start(0);
    check("len0_done", 32'(ld_done_o), 32'h1);
    check("len0_hold", 32'(cpu_hold_o), 32'h1);
    tick();
    check("len0_hold_off", 32'(cpu_hold_o), 32'h0);
    fetch_now("len0_nowrite", 32'h0, 32'h34010005);

    // One word with three idle cycles between bytes.
    rom_ce_i = 1'b0;
    do_start(1);
    for (int i = 0; i < 4; i++) send_byte(prog1[i], (i == 3) ? 0 : 3, 1'b0);
    check("gap_hold_plus1", 32'(cpu_hold_o), 32'h1);
    tick();
    check("gap_hold_plus2", 32'(cpu_hold_o), 32'h0);
    fetch_now("gap_word", 32'h0, 32'hDEADBEEF);

    // Reset after six of eight bytes.
    rom_ce_i = 1'b0;
    do_start(2);
    for (int i = 0; i < 6; i++) send_byte(prog2[i], 0, 1'b0);
    rst = 1'b0;
    #1;
    check("midrst_busy", 32'(ld_busy_o), 32'h0);
    check("midrst_ready", 32'(ld_ready_o), 32'h0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    fetch_now("midrst_w0", 32'h0, 32'h11223344);
    fetch_now("midrst_w1", 32'h4, 32'h3C021234);
    rom_ce_i = 1'b0;

    // Randomized short loads with fetch and start noise.
    noise = 1;
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(1, 6)) tick();
      len = (k == 3) ? 0 : int'($urandom_range(1, 6));
      do_start(len);
      for (int i = 0; i < 4 * len; i++) send_byte(8'($urandom), $urandom_range(0, 2), 1'b1);
      repeat (3) tick();
    end

    // Oversized length is clamped to the full depth.
    do_start(DEPTH + 1);
    cnt = 0;
    for (int i = 1; i <= 4 * DEPTH + 100; i++) begin
      send_byte(8'($urandom), 0, 1'b0);
      cnt = i;
      if (ld_done_o) break;
    end
    check("clamp_bytes", 32'(cnt), 32'(4 * DEPTH));
    tick();

    // Idle fetch traffic over a fully known array, with stray loader bytes.
    for (int i = 0; i < 300; i++) begin
      ld_valid_i = 1'($urandom_range(0, 1));
      ld_byte_i  = 8'($urandom);
      tick();
    end
    ld_valid_i = 1'b0;
    noise = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
